wb_write_arbiter: RTL

Write-side initiator for the 32x32 register file. It merges register writes from the single-cycle pipeline writeback (port A) and a long-latency multi-cycle unit such as mul/div (port B) into the register file's single write port, RDaddr/RDdata/RegWrite. Port A can never stall, so colliding port B results are held in a small FIFO and retired in order when the write port is free. The block sits between the WB stage and the register file.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_write_arbiter_if.sv | 42 ++++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_write_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, request type and log2 helper for the register-file write arbiter
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic int wb_clog2(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - port A/B request and register-file write bundle
// Forwarding lookup signals exist only when WB_FWD_EN is defined.
interface wb_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              a_we_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_data_i;
  logic              b_valid_i;
  logic              b_ready_o;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_data_i;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic              RegWrite_o;
  logic              pending_o;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_addr_i;
  logic              fwd_hit_o;
  logic [DATA_W-1:0] fwd_data_o;
`endif

  modport master (
    output a_we_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    input  b_ready_o, RDaddr_o, RDdata_o, RegWrite_o, pending_o
`ifdef WB_FWD_EN
    , output fwd_addr_i
    , input  fwd_hit_o, fwd_data_o
`endif
  );

  modport slave (
    input  a_we_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    output b_ready_o, RDaddr_o, RDdata_o, RegWrite_o, pending_o
`ifdef WB_FWD_EN
    , input  fwd_addr_i
    , output fwd_hit_o, fwd_data_o
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order queue for port B writes that lost arbitration
// With WB_FWD_EN defined, storage, valid mask and read pointer are exported.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t,
  parameter int  PW    = wb_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count,
  output T              head
`ifdef WB_FWD_EN
  ,
  output T              mem_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PW-1:0] rd_ptr_o
`endif
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries inside the pointer window are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

`ifdef WB_FWD_EN
  assign mem_o    = mem;
  assign rd_ptr_o = rd_ptr;

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline (A) and multi-cycle (B) writes onto the register-file write port
// Optional forwarding lookup over in-flight writes is enabled by WB_FWD_EN.
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_write_arbiter_if.slave bus
);
  import wb_pkg::*;

  localparam int PW = wb_clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              a_sel;
  logic              b_xfer;
  logic              b_live;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [PW:0]       count;
  req_t              b_req;
  req_t              head;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Writes to r0 are dropped here; a B request to r0 is still consumed.
  assign a_sel  = bus.a_we_i && (bus.a_addr_i != '0);
  assign b_xfer = bus.b_valid_i && !full;
  assign b_live = b_xfer && (bus.b_addr_i != '0);
  assign pop    = !a_sel && !empty;
  assign push   = b_live && (a_sel || !empty);
  assign b_req  = '{addr: bus.b_addr_i, data: bus.b_data_i};

`ifdef WB_FWD_EN
  req_t              fifo_mem [DEPTH];
  logic [DEPTH-1:0]  fifo_valid;
  logic [PW-1:0]     fifo_rd_ptr;
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t),
    .PW    (PW)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push     (push),
    .pop      (pop),
    .din      (b_req),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
`ifdef WB_FWD_EN
    ,
    .mem_o    (fifo_mem),
    .valid_o  (fifo_valid),
    .rd_ptr_o (fifo_rd_ptr)
`endif
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else if (a_sel) begin
      reg_write <= 1'b1;
      rd_addr   <= bus.a_addr_i;
      rd_data   <= bus.a_data_i;
    end else if (!empty) begin
      reg_write <= 1'b1;
      rd_addr   <= head.addr;
      rd_data   <= head.data;
    end else if (b_live) begin
      reg_write <= 1'b1;
      rd_addr   <= bus.b_addr_i;
      rd_data   <= bus.b_data_i;
    end else begin
      reg_write <= 1'b0;
    end
  end

  assign bus.RegWrite_o = reg_write;
  assign bus.RDaddr_o   = rd_addr;
  assign bus.RDdata_o   = rd_data;
  assign bus.b_ready_o  = !full;
  assign bus.pending_o  = reg_write || (count != '0);

`ifdef WB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;

  // Scan oldest to youngest so the youngest matching write overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (bus.fwd_addr_i != '0) begin
      if (reg_write && (rd_addr == bus.fwd_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = rd_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = fifo_rd_ptr + PW'(k);
        if (fifo_valid[idx] && (fifo_mem[idx].addr == bus.fwd_addr_i)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_mem[idx].data;
        end
      end
    end
  end

  assign bus.fwd_hit_o  = fwd_hit;
  assign bus.fwd_data_o = fwd_data;
`endif

endmodule
